dma_io_buffered_device: RTL and testbench
=========================================

// Module: dma_io_buffered_device
// PURPOSE
// - Parametrised DMA-capable I/O peripheral with an internal DEPTH-entry buffer.
// - Serves CPU single-beat reads/writes over the IReady/TReady handshake.
// - Runs DREQ/DACK burst transfers in both directions: IO->memory and memory->IO.
// - Sits on the shared system bus beside memory and the DMA controller.
// PARAMETERS
// - DATA_W     8     data bus width
// - ADDR_W     16    address bus width
// - DEPTH      32    buffer entries (power of 2)
// - BASE       1001  first buffer address; status register at BASE+DEPTH
// - BURST_LEN  2     beats per DMA burst, 1..DEPTH
// PORTS
// - clk        in   1       system clock, rising edge
// - rst        in   1       asynchronous reset, active-high
// - addr       in   ADDR_W  address bus
// - data_in    in   DATA_W  data bus, sampled
// - data_out   out  DATA_W  data bus, driven
// - data_oe    out  1       data_out valid on the bus
// - rd_wr      in   1       CPU access type: 1=write, 0=read
// - i_ready    in   1       master (CPU) strobe
// - t_ready    out  1       target acknowledge
// - cpu_event  in   1       rising edge requests a DMA burst
// - dma_dir    in   1       0=IO->mem, 1=mem->IO; sampled at burst start
// - dreq       out  1       DMA request
// - dack       in   1       DMA grant; one beat per clk while high
// - io_flag    out  1       beat valid this cycle
// - done       out  1       one-cycle pulse at burst end
// BEHAVIOUR
// - Reset: all outputs 0; state IDLE; ptr=0; count=0.
// - Reset buffer init: entry i = 2*i mod 2^DATA_W.
// - FSM states: IDLE, CPU_ACK, REQ, XFER, FIN.
// - CPU access: hit when BASE <= addr <= BASE+DEPTH, i_ready rising, dack=0.
//   - Write: store data_in at the next edge.
//   - Read: data_out/data_oe valid the cycle t_ready rises.
//   - t_ready rises 1 clk after the i_ready rise and holds until i_ready falls.
//   - t_ready drops the clk after i_ready falls; data_oe drops with it.
// - Status read at BASE+DEPTH: {busy, ptr} zero-extended.
// - Any i_ready access while dack=1 is deferred, with no t_ready, until dack falls.
// - Burst start: cpu_event rising edge in IDLE -> REQ, dreq=1, count=0, dma_dir latched.
// - REQ -> XFER when dack=1.
// - XFER, per clk with dack=1:
//   - IO->mem: data_out = buf[ptr], data_oe=1, io_flag=1.
//   - mem->IO: buf[ptr] <= data_in, io_flag=1.
//   - Then ptr <= (ptr+1) mod DEPTH (wraps DEPTH-1 -> 0) and count++.
// - Pause: dack=0 mid-burst -> io_flag=0, data_oe=0, dreq held 1; resume when dack returns.
// - Last beat (count = BURST_LEN-1 issued): dreq drops the same edge -> FIN.
// - FIN: wait for dack=0, pulse done, return to IDLE.
// - cpu_event edges outside IDLE are ignored (no queueing).
// - Asynchronous rst mid-burst: immediate return to IDLE, outputs 0, buffer re-initialised.
// - Simultaneous CPU hit and cpu_event in IDLE: CPU access is served first; the request is held pending and taken in the cycle after t_ready drops.
// CONFIGURATION
// - Macro DMA_IO_IRQ_EN:
//   - Defined: adds port irq (out 1).
//     - Set on done; sticky.
//     - Cleared by a CPU write to BASE+DEPTH.
//     - If set and clear land on the same edge, set wins.
//   - Undefined: no irq port; status writes are acknowledged and ignored.
// STRUCTURE
// - Package dma_io_pkg:
//   - state enum;
//   - DIR_IO2MEM=0 and DIR_MEM2IO=1;
//   - the status-register bit layout.
// - Sub-module dma_io_buffer:
//   - DEPTH x DATA_W register array;
//   - one write port, one read port;
//   - reset init pattern.
// - Top holds the FSM, ptr/count, and address decode.
// TESTING
// - CPU write 8'hA5 to 1005, then read 1005 -> t_ready 1 clk after i_ready; read data_out=8'hA5.
// - IO->mem burst, BURST_LEN=2, ptr=0 -> data_out 0 then 2 on consecutive dack clks; done 1 clk after dack falls.
// - mem->IO with ptr=DEPTH-1, data_in 8'h11 then 8'h22 -> buf[31]=8'h11, buf[0]=8'h22, ptr=1.
// - dack low for 3 clks mid-burst -> dreq stays 1, io_flag 0, 2nd beat delivers buf[1].
// - rst asserted during XFER -> dreq, io_flag, done = 0 immediately; buf[3]=6 afterwards.
// - DMA_IO_IRQ_EN defined: burst ends -> irq=1; status write -> irq=0 next clk.

Source files
------------

// File: rtl/dma_io_pkg.sv
// Shared types and constants for the buffered DMA I/O peripheral.
// Purpose: FSM state encoding, DMA direction codes, status register layout.
// Latency/backpressure: n/a (declarations only).
package dma_io_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CPU_ACK = 3'd1,
        REQ     = 3'd2,
        XFER    = 3'd3,
        FIN     = 3'd4
    } state_e;

    localparam logic DIR_IO2MEM = 1'b0;
    localparam logic DIR_MEM2IO = 1'b1;

    // Status register: ptr occupies bits [ptr_w-1:0], busy sits directly above
    // it, every higher bit reads as zero.
    localparam int unsigned STAT_PTR_LSB = 0;

    function automatic logic [31:0] status_word(input logic busy,
                                                input logic [31:0] ptr,
                                                input int unsigned ptr_w);
        return ({31'd0, busy} << ptr_w) | (ptr << STAT_PTR_LSB);
    endfunction

endpackage

// File: rtl/dma_io_buffer.sv
// DEPTH x DATA_W register array, one write port and one combinational read port.
// Latency: write lands at the clock edge; read data is combinational from raddr_i.
// Backpressure: none; the caller owns arbitration between CPU and DMA.
// Ports: we_i/waddr_i/wdata_i write port; raddr_i/rdata_o read port.
// Reset loads entry i with 2*i (mod 2^DATA_W) so the contents are predictable.
module dma_io_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DATA_W-1:0]        rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DATA_W'(2 * i);
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dma_io_buffered_device.sv
// DMA-capable I/O peripheral: CPU single-beat access to a DEPTH-entry buffer
// plus DREQ/DACK bursts of BURST_LEN beats in either direction.
// Latency: t_ready (and read data) 1 clk after i_ready rises; one DMA beat per clk with dack high.
// Backpressure: CPU access deferred while a burst owns the buffer; dack low pauses a burst.
// Ports: addr/data_in/rd_wr/i_ready -> t_ready/data_out/data_oe (CPU side);
//        cpu_event/dma_dir/dack -> dreq/io_flag/done (DMA side); status at BASE+DEPTH.
// Optional: define DMA_IO_IRQ_EN to add a sticky irq output set on done and
//           cleared by a CPU write to the status address.
module dma_io_buffered_device #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 32,
    parameter int BASE      = 1001,
    parameter int BURST_LEN = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_oe,
    input  logic              rd_wr,
    input  logic              i_ready,
    output logic              t_ready,
    input  logic              cpu_event,
    input  logic              dma_dir,
    output logic              dreq,
    input  logic              dack,
    output logic              io_flag,
    output logic              done
`ifdef DMA_IO_IRQ_EN
    ,
    output logic              irq
`endif
);
    import dma_io_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] STAT_A = ADDR_W'(BASE + DEPTH);

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dir_q, dir_d;
    logic              t_ready_q, t_ready_d;
    logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
    logic              cpu_oe_q, cpu_oe_d;
    logic              done_q, done_d;
    logic              irdy_q, evt_q;
    logic              cpu_pend_q, cpu_pend_d;
    logic              evt_pend_q, evt_pend_d;

    logic              cpu_hit, is_stat, cpu_rise, cpu_req, evt_rise;
    logic              in_burst, beat, last_beat, busy, buf_we;
    logic [PTR_W-1:0]  cpu_idx, buf_addr;
    logic [DATA_W-1:0] buf_rdata, status_dat;

    // Address decode: buffer window plus the status word just past it.
    assign cpu_hit  = (addr >= BASE_A) && (addr <= STAT_A);
    assign is_stat  = (addr == STAT_A);
    assign cpu_idx  = PTR_W'(addr - BASE_A);

    assign cpu_rise = i_ready & ~irdy_q;
    assign evt_rise = cpu_event & ~evt_q;
    // An access that rose while the buffer was busy stays pending until served.
    assign cpu_req  = i_ready & (cpu_rise | cpu_pend_q) & cpu_hit & ~dack;

    assign in_burst  = (state_q == REQ) || (state_q == XFER);
    assign beat      = in_burst & dack;
    assign last_beat = beat && (cnt_q == CNT_W'(BURST_LEN - 1));

    assign busy       = evt_pend_q | (state_q == REQ) | (state_q == XFER) | (state_q == FIN);
    assign status_dat = DATA_W'(status_word(busy, 32'(ptr_q), PTR_W));

    // The DMA pointer owns the buffer during a burst; otherwise the CPU index does.
    assign buf_addr = in_burst ? ptr_q : cpu_idx;
    assign buf_we   = (beat && (dir_q == DIR_MEM2IO)) ||
                      ((state_q == IDLE) && cpu_req && rd_wr && !is_stat);

    dma_io_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .we_i    (buf_we),
        .waddr_i (buf_addr),
        .wdata_i (data_in),
        .raddr_i (buf_addr),
        .rdata_o (buf_rdata)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        dir_d      = dir_q;
        t_ready_d  = t_ready_q;
        cpu_dout_d = cpu_dout_q;
        cpu_oe_d   = cpu_oe_q;
        done_d     = 1'b0;
        evt_pend_d = evt_pend_q;
        cpu_pend_d = (cpu_pend_q | cpu_rise) & i_ready;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    // CPU wins a tie with cpu_event; the event is parked.
                    state_d    = CPU_ACK;
                    t_ready_d  = 1'b1;
                    cpu_pend_d = 1'b0;
                    if (!rd_wr) begin
                        cpu_dout_d = is_stat ? status_dat : buf_rdata;
                        cpu_oe_d   = 1'b1;
                    end
                    if (evt_rise) evt_pend_d = 1'b1;
                end else if (evt_rise || evt_pend_q) begin
                    state_d    = REQ;
                    evt_pend_d = 1'b0;
                    cnt_d      = '0;
                    dir_d      = dma_dir;
                end
            end
            CPU_ACK: begin
                if (!i_ready) begin
                    state_d   = IDLE;
                    t_ready_d = 1'b0;
                    cpu_oe_d  = 1'b0;
                end
            end
            REQ, XFER: begin
                if (beat) begin
                    ptr_d   = ptr_q + PTR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = last_beat ? FIN : XFER;
                end
            end
            FIN: begin
                if (!dack) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dir_q      <= DIR_IO2MEM;
            t_ready_q  <= 1'b0;
            cpu_dout_q <= '0;
            cpu_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            irdy_q     <= 1'b0;
            evt_q      <= 1'b0;
            cpu_pend_q <= 1'b0;
            evt_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            t_ready_q  <= t_ready_d;
            cpu_dout_q <= cpu_dout_d;
            cpu_oe_q   <= cpu_oe_d;
            done_q     <= done_d;
            irdy_q     <= i_ready;
            evt_q      <= cpu_event;
            cpu_pend_q <= cpu_pend_d;
            evt_pend_q <= evt_pend_d;
        end
    end

    // DMA beat data is driven combinationally in the dack cycle; CPU read
    // data is the registered copy captured when t_ready rose.
    always_comb begin
        data_out = cpu_dout_q;
        data_oe  = cpu_oe_q;
        if (beat && (dir_q == DIR_IO2MEM)) begin
            data_out = buf_rdata;
            data_oe  = 1'b1;
        end
    end

    assign t_ready = t_ready_q;
    assign dreq    = in_burst;
    assign io_flag = beat;
    assign done    = done_q;

`ifdef DMA_IO_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = irq_q;
        if ((state_q == IDLE) && cpu_req && rd_wr && is_stat) irq_d = 1'b0;
        if (done_d) irq_d = 1'b1;   // set beats clear on the same edge
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_dma_io_buffered_device.sv
// Bench for dma_io_buffered_device: directed CPU/DMA scenarios plus random bursts,
// checked against a behavioural model of buffer contents, pointer and irq.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_dma_io_buffered_device;
    localparam int DW   = 8;
    localparam int AW   = 16;
    localparam int DEP  = 32;
    localparam int BASE = 1001;
    localparam int BL   = 2;
    localparam logic [AW-1:0] STAT = AW'(BASE + DEP);

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          data_oe, rd_wr, i_ready, t_ready;
    logic          cpu_event, dma_dir, dreq, dack, io_flag, done;
`ifdef DMA_IO_IRQ_EN
    logic          irq;
`endif

    always #5 clk = ~clk;

    dma_io_buffered_device #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .BASE(BASE), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(data_in),
        .data_out(data_out), .data_oe(data_oe), .rd_wr(rd_wr),
        .i_ready(i_ready), .t_ready(t_ready), .cpu_event(cpu_event),
        .dma_dir(dma_dir), .dreq(dreq), .dack(dack), .io_flag(io_flag),
        .done(done)
`ifdef DMA_IO_IRQ_EN
        , .irq(irq)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model
    logic [7:0] ref_buf [DEP];
    int         ref_ptr;
    bit         ref_irq;

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) ref_buf[i] = 8'(2 * i);
        ref_ptr = 0;
        ref_irq = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("%s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_irq(input string tag);
`ifdef DMA_IO_IRQ_EN
        chk(tag, irq, ref_irq);
`endif
    endtask

    // One CPU handshake: i_ready up, expect t_ready one clock later (if hit), then release.
    task automatic cpu_access(input logic [AW-1:0] a, input logic wr, input logic [7:0] wd,
                              input logic [7:0] exp_rd, input bit hit);
        @(negedge clk);
        addr = a; rd_wr = wr; data_in = wd; i_ready = 1'b1;
        #1 chk("t_ready_early", t_ready, 0);
        @(negedge clk);
        #1;
        if (hit) begin
            chk("t_ready_rise", t_ready, 1);
            if (!wr) begin
                chk("rd_oe", data_oe, 1);
                chk("rd_data", data_out, exp_rd);
            end
        end else begin
            chk("miss_no_t_ready", t_ready, 0);
        end
        i_ready = 1'b0;
        @(negedge clk);
        #1 chk("t_ready_fall", t_ready, 0);
        chk("oe_fall", data_oe, 0);
    endtask

    task automatic cpu_wr(input int idx, input logic [7:0] d);
        cpu_access(AW'(BASE + idx), 1'b1, d, 8'h00, 1'b1);
        ref_buf[idx] = d;
    endtask

    task automatic cpu_rd(input int idx);
        cpu_access(AW'(BASE + idx), 1'b0, 8'h00, ref_buf[idx], 1'b1);
    endtask

    task automatic stat_rd();
        cpu_access(STAT, 1'b0, 8'h00, 8'(ref_ptr), 1'b1);
    endtask

    task automatic stat_wr(input logic [7:0] d);
        cpu_access(STAT, 1'b1, d, 8'h00, 1'b1);
        ref_irq = 0;
        chk_irq("irq_cleared");
    endtask

    // One DMA burst of BL beats; optional pause before later beats and an
    // optional CPU read raised during the burst that must wait for its end.
    task automatic burst(input bit launch, input logic dir, input int pause,
                         input int defer_idx, input logic [7:0] d0, input logic [7:0] d1);
        if (launch) begin
            @(negedge clk);
            cpu_event = 1'b1; dma_dir = dir;
            #1 chk("dreq_idle", dreq, 0);
            @(negedge clk);
            cpu_event = 1'b0;
            #1 chk("dreq_req", dreq, 1);
            chk("io_flag_req", io_flag, 0);
        end
        for (int b = 0; b < BL; b++) begin
            if (b > 0) begin
                for (int p = 0; p < pause; p++) begin
                    @(negedge clk);
                    dack = 1'b0;
                    #1 chk("pause_dreq", dreq, 1);
                    chk("pause_io_flag", io_flag, 0);
                    chk("pause_oe", data_oe, 0);
                end
                @(negedge clk);
            end
            if (b == 1) cpu_event = 1'b1;   // edge outside IDLE must be ignored
            if (b == 0 && defer_idx >= 0) begin
                addr = AW'(BASE + defer_idx); rd_wr = 1'b0; i_ready = 1'b1;
            end
            dack = 1'b1;
            data_in = (b == 0) ? d0 : d1;
            #1 chk("beat_io_flag", io_flag, 1);
            chk("beat_dreq", dreq, 1);
            chk("beat_no_t_ready", t_ready, 0);
            if (dir == 1'b0) begin
                chk("beat_data", data_out, ref_buf[ref_ptr]);
                chk("beat_oe", data_oe, 1);
            end else begin
                chk("beat_oe_in", data_oe, 0);
                ref_buf[ref_ptr] = data_in;
            end
            ref_ptr = (ref_ptr + 1) % DEP;
        end
        @(negedge clk);
        dack = 1'b0; cpu_event = 1'b0;
        #1 chk("fin_dreq", dreq, 0);
        chk("fin_done", done, 0);
        chk("fin_io_flag", io_flag, 0);
        @(negedge clk);
        #1 chk("done_pulse", done, 1);
        chk("done_t_ready", t_ready, 0);
        ref_irq = 1;
        chk_irq("irq_set");
        @(negedge clk);
        #1 chk("done_clear", done, 0);
        chk("post_dreq", dreq, 0);
        if (defer_idx >= 0) begin
            chk("defer_t_ready", t_ready, 1);
            chk("defer_data", data_out, ref_buf[defer_idx]);
            i_ready = 1'b0;
            @(negedge clk);
            #1 chk("defer_release", t_ready, 0);
        end
    endtask

    initial begin
        rst = 1'b1; addr = '0; data_in = '0; rd_wr = 1'b0; i_ready = 1'b0;
        cpu_event = 1'b0; dma_dir = 1'b0; dack = 1'b0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        #1 chk("rst_dreq", dreq, 0);
        chk("rst_io_flag", io_flag, 0);
        chk("rst_done", done, 0);
        chk("rst_t_ready", t_ready, 0);
        chk("rst_oe", data_oe, 0);
        chk("rst_data", data_out, 0);
        chk_irq("rst_irq");
        rst = 1'b0;

        // CPU write/read, status, and out-of-window addresses
        cpu_wr(4, 8'hA5);
        cpu_rd(4);
        stat_rd();
        cpu_access(AW'(BASE - 1), 1'b0, 8'h00, 8'h00, 1'b0);
        cpu_access(AW'(BASE + DEP + 1), 1'b1, 8'h77, 8'h00, 1'b0);
        cpu_rd(DEP - 1);

        // IO->mem from ptr 0 (expects 0 then 2), then with a 3-clk dack pause
        burst(1'b1, 1'b0, 0, -1, 8'h00, 8'h00);
        burst(1'b1, 1'b0, 3, -1, 8'h00, 8'h00);
        stat_rd();

        // Status write: acknowledged, no buffer side effect
        stat_wr(8'hFF);
        stat_rd();
        cpu_rd(0);

        // Random bursts and CPU traffic; 13 bursts carry ptr from 4 to 30
        for (int k = 0; k < 13; k++) begin
            int   defer, idx;
            logic dir;
            dir   = 1'($urandom_range(0, 1));
            defer = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, DEP - 1)) : -1;
            burst(1'b1, dir, int'($urandom_range(0, 2)), defer, 8'($urandom), 8'($urandom));
            idx = int'($urandom_range(0, DEP - 1));
            cpu_wr(idx, 8'($urandom));
            cpu_rd(int'($urandom_range(0, DEP - 1)));
            cpu_rd(idx);
        end
        stat_rd();

        // mem->IO across the wrap: entries 30, 31 then ptr back to 0
        burst(1'b1, 1'b1, 0, -1, 8'h11, 8'h22);
        cpu_rd(DEP - 2);
        cpu_rd(DEP - 1);
        stat_rd();

        // CPU hit and cpu_event together: CPU first, burst starts after t_ready drops
        @(negedge clk);
        addr = AW'(BASE + 5); rd_wr = 1'b0; i_ready = 1'b1; cpu_event = 1'b1; dma_dir = 1'b1;
        @(negedge clk);
        #1 chk("tie_t_ready", t_ready, 1);
        chk("tie_data", data_out, ref_buf[5]);
        chk("tie_dreq", dreq, 0);
        i_ready = 1'b0; cpu_event = 1'b0;
        @(negedge clk);
        #1 chk("tie_t_ready_fall", t_ready, 0);
        chk("tie_dreq_wait", dreq, 0);
        @(negedge clk);
        #1 chk("tie_dreq_taken", dreq, 1);
        burst(1'b0, 1'b1, 1, -1, 8'($urandom), 8'($urandom));
        stat_rd();
        stat_wr(8'h00);

        // Asynchronous reset in the middle of a burst
        @(negedge clk);
        cpu_event = 1'b1; dma_dir = 1'b0;
        @(negedge clk);
        cpu_event = 1'b0;
        #1 chk("rb_dreq", dreq, 1);
        dack = 1'b1;
        #1 chk("rb_io_flag", io_flag, 1);
        rst = 1'b1;
        #1 chk("rb_dreq_rst", dreq, 0);
        chk("rb_io_flag_rst", io_flag, 0);
        chk("rb_done_rst", done, 0);
        chk("rb_oe_rst", data_oe, 0);
        @(negedge clk);
        dack = 1'b0;
        #1 chk("rb_dreq_hold", dreq, 0);
        rst = 1'b0;
        model_reset();
        chk_irq("rb_irq");
        cpu_rd(3);
        cpu_rd(4);
        stat_rd();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
